// File: rtl/secuenciador_paso_doble.sv
// secuenciador_paso_doble: two-phase-on (double-step) sequencer for a 28BYJ-48
// unipolar stepper behind a ULN2003 driver. Rising edges of the divider's
// square wave (pulsoPaso) pace a commanded move of numPasos steps in the
// direction given by sentido, with an inicio / ocupado / terminado handshake.
//
// Build option: define HOLD_TORQUE_EN to keep the last pattern energized
// while idle once at least one step has been executed since reset. Leave it
// undefined to release the coils (0000) whenever no move is in progress.
module secuenciador_paso_doble #(
  parameter int ANCHO_PASOS = 12
) (
  input  logic                   relojNexys2,
  input  logic                   reset,
  input  logic                   pulsoPaso,
  input  logic                   inicio,
  input  logic                   sentido,
  input  logic [ANCHO_PASOS-1:0] numPasos,
  output logic [3:0]             bobinas,
  output logic                   ocupado,
  output logic                   terminado,
  output logic [ANCHO_PASOS-1:0] pasosRestantes
);

  typedef enum logic [1:0] {
    REPOSO  = 2'd0,
    GIRANDO = 2'd1,
    FIN     = 2'd2
  } estado_t;

  estado_t    estado;
  logic [1:0] indice;
  logic [1:0] indiceSig;
  logic       pulsoPrev;
  logic       tick;
  logic [3:0] bobinasReposo;

  // Coil pattern for each phase index: two adjacent coils energized.
  function automatic logic [3:0] patron(input logic [1:0] i);
    logic [3:0] p;
    case (i)
      2'd0:    p = 4'b1100;
      2'd1:    p = 4'b0110;
      2'd2:    p = 4'b0011;
      default: p = 4'b1001;
    endcase
    return p;
  endfunction

  // One tick per rising edge of the step-rate wave; a held-high level steps once.
  assign tick = pulsoPaso & ~pulsoPrev;

  // Next phase index; the 2-bit arithmetic wraps 3->0 forward and 0->3 reverse.
  assign indiceSig = sentido ? (indice + 2'd1) : (indice - 2'd1);

`ifdef HOLD_TORQUE_EN
  logic pasoEjecutado;

  // Coils stay dark after reset until the first real step, then hold position.
  assign bobinasReposo = pasoEjecutado ? patron(indice) : 4'b0000;

  // Remembers whether any step has been executed since reset.
  always_ff @(posedge relojNexys2) begin
    if (reset) begin
      pasoEjecutado <= 1'b0;
    end else if (estado == GIRANDO && tick) begin
      pasoEjecutado <= 1'b1;
    end
  end
`else
  // Coils released whenever no move is running.
  assign bobinasReposo = 4'b0000;
`endif

  // Edge-detector history for the step-rate input.
  always_ff @(posedge relojNexys2) begin
    if (reset) begin
      pulsoPrev <= 1'b0;
    end else begin
      pulsoPrev <= pulsoPaso;
    end
  end

  // Move sequencer; every output is a register updated alongside the state.
  always_ff @(posedge relojNexys2) begin
    if (reset) begin
      estado         <= REPOSO;
      indice         <= 2'd0;
      bobinas        <= 4'b0000;
      ocupado        <= 1'b0;
      terminado      <= 1'b0;
      pasosRestantes <= '0;
    end else begin
      case (estado)
        REPOSO: begin
          terminado <= 1'b0;
          ocupado   <= 1'b0;
          bobinas   <= bobinasReposo;
          // A tick landing on the accepting edge is deliberately not a step.
          if (inicio) begin
            if (numPasos != '0) begin
              pasosRestantes <= numPasos;
              ocupado        <= 1'b1;
              bobinas        <= patron(indice);
              estado         <= GIRANDO;
            end else begin
              estado <= FIN;
            end
          end
        end

        GIRANDO: begin
          ocupado <= 1'b1;
          if (tick) begin
            indice         <= indiceSig;
            bobinas        <= patron(indiceSig);
            pasosRestantes <= pasosRestantes - 1'b1;
            // Leaving here on the last step keeps the counter from underflowing.
            if (pasosRestantes == {{(ANCHO_PASOS-1){1'b0}}, 1'b1}) begin
              estado <= FIN;
            end
          end
        end

        FIN: begin
          terminado <= 1'b1;
          ocupado   <= 1'b0;
          bobinas   <= bobinasReposo;
          estado    <= REPOSO;
        end

        default: begin
          estado <= REPOSO;
        end
      endcase
    end
  end

endmodule
